// File: rtl/apb_ram_slave_pkg.sv
// Shared widths and FSM encoding for the APB RAM slave.
package apb_ram_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

endpackage

// File: rtl/apb_ram_slave_if.sv
// APB bus bundle shared by the slave and its masters/benches.
interface abp_if
  import apb_ram_pkg::*;
  #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
  );
  logic              pclk;
  logic              presetn;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  pclk, presetn, prdata, pready, pslverr,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    input  pclk, presetn, psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_ram_slave.sv
// APB slave over a DEPTH x DATA_W register-file RAM; one wait state per transfer,
// out-of-range addresses complete with pslverr. All outputs registered.
module apb_ram_slave
  import apb_ram_pkg::*;
  #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
  ) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
  );

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              addr_err;

  // Any bit above the index range, or an index past DEPTH, is an error.
  assign addr_err = (paddr >= ADDR_W'(DEPTH));
  assign idx      = paddr[IDX_W-1:0];

  // presetn is active-high despite its bus-style name.
  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      state   <= ST_IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (psel) begin
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else if (penable) begin
            state  <= ST_ACCESS;
            pready <= 1'b1;
            if (addr_err) begin
              pslverr <= 1'b1;
              prdata  <= '0;
            end else if (pwrite) begin
              mem[idx] <= pwdata;
              prdata   <= '0;
            end else begin
              prdata <= mem[idx];
            end
          end
        end
        ST_ACCESS: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          // psel held with penable low means the master is already in the next setup.
          state   <= (psel && !penable) ? ST_SETUP : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_ram_slave.sv
// Self-checking bench for apb_ram_slave: directed vector table, hand-written corner cases, random vs. model.
module tb_apb_ram_slave;
  import apb_ram_pkg::*;

  abp_if bus ();

  apb_ram_slave dut (
    .pclk    (bus.pclk),
    .presetn (bus.presetn),
    .psel    (bus.psel),
    .penable (bus.penable),
    .pwrite  (bus.pwrite),
    .paddr   (bus.paddr),
    .pwdata  (bus.pwdata),
    .prdata  (bus.prdata),
    .pready  (bus.pready),
    .pslverr (bus.pslverr)
  );

  initial bus.pclk = 1'b0;
  always #5 bus.pclk = ~bus.pclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          gap;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [DEPTH_DEF];
  vec_t        vecs  [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    repeat (n) @(negedge bus.pclk);
  endtask

  // One APB transfer starting with a setup phase now; returns on the negedge where pready is seen.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    int lat;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = w;
    bus.paddr   = a;
    bus.pwdata  = d;
    @(negedge bus.pclk);
    chk("pready_low_in_setup", {31'd0, bus.pready}, 32'd0);
    bus.penable = 1'b1;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge bus.pclk);
      if (bus.pready === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("pready_latency", 32'(lat), 32'd1);
    rd = bus.prdata;
    er = bus.pslverr;
    bus.penable = 1'b0;
  endtask

  task automatic run(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_err, input string tag);
    logic [31:0] rd;
    logic        er;
    xfer(w, a, d, rd, er);
    chk({tag, "_prdata"}, rd, exp_rd);
    chk({tag, "_pslverr"}, {31'd0, er}, {31'd0, exp_err});
    if (w && a < DEPTH_DEF) model[a] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH_DEF; i++) model[i] = 32'd0;
  endtask

  initial begin
    bus.presetn = 1'b1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    clear_model();

    vecs[0]  = '{0, 32'd7,          32'h0,        32'h0,        0, 1};
    vecs[1]  = '{1, 32'd5,          32'hDEADBEEF, 32'h0,        0, 0};
    vecs[2]  = '{0, 32'd5,          32'h0,        32'hDEADBEEF, 0, 2};
    vecs[3]  = '{1, 32'd0,          32'h11111111, 32'h0,        0, 0};
    vecs[4]  = '{1, 32'd31,         32'h22222222, 32'h0,        0, 1};
    vecs[5]  = '{0, 32'd0,          32'h0,        32'h11111111, 0, 0};
    vecs[6]  = '{0, 32'd31,         32'h0,        32'h22222222, 0, 1};
    vecs[7]  = '{1, 32'd32,         32'hCAFEF00D, 32'h0,        1, 0};
    vecs[8]  = '{0, 32'd32,         32'h0,        32'h0,        1, 0};
    vecs[9]  = '{0, 32'hFFFFFFFF,   32'h0,        32'h0,        1, 1};
    vecs[10] = '{0, 32'd0,          32'h0,        32'h11111111, 0, 1};

    repeat (5) @(negedge bus.pclk);
    chk("reset_pready",  {31'd0, bus.pready},  32'd0);
    chk("reset_pslverr", {31'd0, bus.pslverr}, 32'd0);
    chk("reset_prdata",  bus.prdata,           32'd0);
    bus.presetn = 1'b0;
    @(negedge bus.pclk);

    for (int i = 0; i < 11; i++) begin
      run(vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, vecs[i].exp_err,
          $sformatf("vec%0d", i));
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end
    idle(1);

    // Setup phase stretched by the master: pready must wait for penable.
    bus.psel   = 1'b1;
    bus.pwrite = 1'b0;
    bus.paddr  = 32'd31;
    repeat (3) @(negedge bus.pclk);
    chk("stall_pready_low", {31'd0, bus.pready}, 32'd0);
    bus.penable = 1'b1;
    @(negedge bus.pclk);
    chk("stall_pready", {31'd0, bus.pready}, 32'd1);
    chk("stall_prdata", bus.prdata, 32'h22222222);
    @(negedge bus.pclk);
    chk("stall_pready_drop", {31'd0, bus.pready}, 32'd0);
    chk("stall_prdata_hold", bus.prdata, 32'h22222222);
    idle(1);

    // Abandoned setup must not write; penable alone in idle is ignored.
    bus.psel   = 1'b1;
    bus.pwrite = 1'b1;
    bus.paddr  = 32'd9;
    bus.pwdata = 32'hAAAA5555;
    @(negedge bus.pclk);
    bus.psel    = 1'b0;
    bus.penable = 1'b1;
    repeat (3) @(negedge bus.pclk);
    chk("idle_penable_ignored", {31'd0, bus.pready}, 32'd0);
    bus.penable = 1'b0;
    @(negedge bus.pclk);
    run(0, 32'd9, 32'h0, 32'h0, 0, "abandoned_rd9");
    idle(1);

    // Reset asserted during the access cycle of a completed write.
    bus.psel   = 1'b1;
    bus.pwrite = 1'b1;
    bus.paddr  = 32'd3;
    bus.pwdata = 32'h12345678;
    @(negedge bus.pclk);
    bus.penable = 1'b1;
    @(negedge bus.pclk);
    chk("rstmid_pready_before", {31'd0, bus.pready}, 32'd1);
    #1 bus.presetn = 1'b1;
    #1;
    chk("rstmid_pready_async", {31'd0, bus.pready}, 32'd0);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    clear_model();
    repeat (3) @(negedge bus.pclk);
    bus.presetn = 1'b0;
    @(negedge bus.pclk);
    run(0, 32'd3,  32'h0, 32'h0, 0, "rstmid_rd3");
    run(0, 32'd31, 32'h0, 32'h0, 0, "rstmid_rd31");
    idle(1);

    for (int i = 0; i < 20; i++) begin
      bit          w;
      logic [31:0] a, d, exp_rd;
      bit          exp_err;
      int          gap;
      w       = 1'($urandom_range(0, 1));
      a       = 32'($urandom_range(0, 40));
      d       = $urandom;
      gap     = $urandom_range(0, 2);
      exp_err = (a >= DEPTH_DEF);
      exp_rd  = (exp_err || w) ? 32'h0 : model[a];
      run(w, a, d, exp_rd, exp_err, $sformatf("rnd%0d", i));
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
